// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer stages (FC1/FC2).
// Holds the default datapath widths, the MAC controller state encoding and
// the read latency of the registered FC1 result / weight ROM ports.
package fc_pkg;

    // Default datapath widths
    localparam int FC_D_W   = 16;   // signed data / weight width
    localparam int FC_ACC_W = 23;   // signed accumulator width per lane
    localparam int FC_FRAC  = 8;    // fraction bits dropped from each product

    // Cycles from address to data on the registered read ports
    localparam int FC_RD_LAT = 2;

    // The DRAIN state covers the read latency and the product and accumulate
    // registers.
    localparam int FC_DRAIN_CYC = FC_RD_LAT + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc2_lane.sv
// One FC2 output lane: registered signed multiply, arithmetic shift by FRAC,
// and accumulate.
// With FC2_SAT_EN defined, the shifted term and the running sum saturate to
// the ACC_W signed range. Otherwise they truncate and wrap modulo 2^ACC_W.
// Ports:
//   clk    - clock
//   clr    - synchronous clear of the accumulator (reset or new run)
//   mul_en - capture the product of a and b
//   acc_en - add the registered product term into the accumulator
//   a, b   - signed operands (FC1 result, weight)
//   acc    - accumulator value
module fc2_lane #(
    parameter int D_W   = 16,
    parameter int ACC_W = 23,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             mul_en,
    input  logic             acc_en,
    input  logic [D_W-1:0]   a,
    input  logic [D_W-1:0]   b,
    output logic [ACC_W-1:0] acc
);

    localparam int PW = 2 * D_W;

    logic signed [PW-1:0]    prod_p2;
    logic signed [PW-1:0]    shifted;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] acc_p3;

`ifdef FC2_SAT_EN
    function automatic logic signed [ACC_W-1:0] sat_term(input logic signed [PW-1:0] v);
        // The value fits if every bit above the ACC_W sign bit matches it.
        if (v[PW-1:ACC_W-1] == {(PW-ACC_W+1){v[PW-1]}})
            return v[ACC_W-1:0];
        else if (v[PW-1])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] x,
                                                        input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            return s[ACC_W-1:0];
    endfunction
`endif

    // ---- stage p2: product register (operands valid in p1) ----
    always_ff @(posedge clk) begin
        if (mul_en)
            prod_p2 <= $signed(a) * $signed(b);
    end

    assign shifted = prod_p2 >>> FRAC;

`ifdef FC2_SAT_EN
    assign term    = sat_term(shifted);
    assign acc_nxt = sat_add(acc_p3, term);
`else
    logic unused_hi;
    assign term      = shifted[ACC_W-1:0];
    assign acc_nxt   = acc_p3 + term;
    assign unused_hi = ^shifted[PW-1:ACC_W];
`endif

    // ---- stage p3: accumulator ----
    always_ff @(posedge clk) begin
        if (clr)
            acc_p3 <= '0;
        else if (acc_en)
            acc_p3 <= acc_nxt;
    end

    assign acc = acc_p3;

endmodule

// File: rtl/fc2_mac.sv
// FC2 MAC engine. It reads N_IN FC1 results and the matching weight rows,
// and accumulates N_OUT dot products in parallel.
// Optional feature: define FC2_SAT_EN for saturating accumulation. Without
// it, accumulation wraps.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request a run; accepted only in IDLE
//   busy      - high from the accepted start until done
//   done      - one-cycle pulse when mac_4 holds the finished result
//   f6_raddr  - FC1 result read address; data returns 2 cycles later
//   f6_rdata  - FC1 result
//   w_raddr   - weight ROM row address, always equal to f6_raddr
//   w_rdata   - weight row, lane j at [D_W*j +: D_W]
//   mac_4     - accumulators, lane j at [ACC_W*j +: ACC_W]
module fc2_mac
    import fc_pkg::*;
#(
    parameter int N_IN  = 120,
    parameter int N_OUT = 84,
    parameter int D_W   = FC_D_W,
    parameter int ACC_W = FC_ACC_W,
    parameter int FRAC  = FC_FRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             f6_raddr,
    input  logic [D_W-1:0]         f6_rdata,
    output logic [6:0]             w_raddr,
    input  logic [N_OUT*D_W-1:0]   w_rdata,
    output logic [N_OUT*ACC_W-1:0] mac_4
);

    fc_state_t  state, state_nxt;
    logic [6:0] cnt;
    logic       issue;
    logic       accept;
    logic       clr;
    logic       vld_p0, vld_p1, vld_p2;

    assign issue  = (state == READ);
    assign accept = (state == IDLE) && start;
    assign clr    = rst || accept;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (cnt == 7'(N_IN - 1)) state_nxt = DRAIN;
            DRAIN:   if (cnt == 7'(FC_DRAIN_CYC - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter holds the read index in READ and the drain cycle in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                READ:    cnt <= (cnt == 7'(N_IN - 1)) ? 7'd0 : cnt + 7'd1;
                DRAIN:   cnt <= cnt + 7'd1;
                default: cnt <= '0;
            endcase
        end
    end

    assign busy     = (state == READ) || (state == DRAIN);
    assign done     = (state == DONE);
    assign f6_raddr = issue ? cnt : 7'd0;
    assign w_raddr  = f6_raddr;

    // ---- valid pipe: p0 address issued, p1 read data valid, p2 product valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        fc2_lane #(
            .D_W  (D_W),
            .ACC_W(ACC_W),
            .FRAC (FRAC)
        ) u_lane (
            .clk   (clk),
            .clr   (clr),
            .mul_en(vld_p1),
            .acc_en(vld_p2),
            .a     (f6_rdata),
            .b     (w_rdata[D_W*j +: D_W]),
            .acc   (mac_4[ACC_W*j +: ACC_W])
        );
    end

endmodule
